doppler_ramp_ctrl: RTL and testbench
====================================

Name: doppler_ramp_ctrl

Overview:
Sequencer that drives the doppler NCO's `dv_in`/`freq` inputs. It accepts linear doppler segments from software or the trajectory engine through a valid/ready interface. Each segment is a start phase increment, a per-sample slope and a length. It plays them sample-by-sample on an external sample strobe. One segment can be queued behind the active one, so back-to-back segments run with no gap.

Parameters:
FREQ_W, 32, width of NCO frequency word (phase increment)
RATE_W, 24, width of signed per-sample frequency slope
CNT_W, 20, width of segment length field

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
cfg_valid  in  1  segment descriptor valid
cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready
cfg_freq  in  FREQ_W  start frequency word of segment
cfg_rate  in  RATE_W  signed slope, added per emitted sample
cfg_len  in  CNT_W  samples in segment; 0 = unbounded
abort  in  1  synchronous stop, clears queue
sample_en  in  1  sample strobe (one NCO sample per pulse)
nco_dv  out  1  to NCO dv_in
nco_freq  out  FREQ_W  to NCO freq; valid whenever nco_dv=1
busy  out  1  state != IDLE
seg_done  out  1  one-cycle pulse with last sample of a bounded segment
underrun  out  1  one-cycle pulse: segment ended with queue empty

Behaviour:
- Reset (async, reset=0): state IDLE; nco_dv, nco_freq, seg_done, underrun, busy = 0; pending slot empty; accumulator and counter = 0.
- cfg_ready = !pend_full (combinational). It reads 1 during reset and after reset.
- An accepted descriptor is always written to the one-deep pending slot. Pending status is evaluated from the registered pend_full only. A descriptor accepted in the same cycle as a segment end is not seen until the next cycle.
- States:
  - IDLE: nco_dv=0 and nco_freq holds. On sample_en with pend_full → RUN via load.
  - RUN: each sample_en emits one sample.
  - HOLD: each sample_en emits nco_dv=1 with nco_freq unchanged (last emitted value). On sample_en with pend_full → load, go RUN.
- Load (on a sample_en):
  - nco_freq <= pend_freq; acc <= pend_freq + sext(pend_rate); cnt <= 1.
  - len <= pend_len; pend_full <= 0.
  - If pend_len == 1, the segment-end check below applies in the same cycle.
- RUN emit (sample_en, not the last sample):
  - nco_freq <= acc; acc <= acc + sext(rate); cnt <= cnt+1.
- Segment end, when the emitted count reaches len (len != 0):
  - seg_done pulses with that sample's nco_dv.
  - If pend_full at that moment: the next sample_en performs a load. There is no gap, no underrun, and state stays RUN.
  - Else: underrun pulses in the same cycle as seg_done, and state becomes HOLD.
- len == 0 (unbounded): never ends on count. If pend_full at a sample_en, that sample performs a load instead of an emit (takeover). No seg_done is generated.
- Latency: nco_dv asserts exactly 1 clk after sample_en, one pulse per sample_en, and only in RUN/HOLD or on a load. nco_freq changes only in cycles where nco_dv=1.
- Arithmetic: modulo 2^FREQ_W wrap, no saturation. Rate is sign-extended to FREQ_W. The counter is CNT_W+1 bits internally.
- abort (highest priority, synchronous):
  - Next cycle: state IDLE, pend_full=0, nco_dv=0, no seg_done/underrun.
  - nco_freq holds its last value.
  - A cfg handshake in the same cycle as abort is discarded.
- sample_en in IDLE with no pending descriptor is ignored.
- Reset asserted mid-segment: all outputs go to their reset values immediately, independent of clk.

Test Plan:
1. Reset, then cfg freq=0x01234567, rate=0, len=4; sample_en every 2nd clk.
   - Required: 4 nco_dv pulses, each 1 clk after its sample_en, all with freq 0x01234567.
   - Required: seg_done+underrun with the 4th pulse, then HOLD pulses at 0x01234567.
2. cfg freq=0x100, rate=+0x10, len=3, then queue freq=0x02468ACE, rate=-1, len=2.
   - Required sequence: 0x100, 0x110, 0x120, 0x02468ACE, 0x02468ACD on consecutive sample_en pulses.
   - Required: seg_done on the 3rd and 5th; underrun only on the 5th.
3. Wrap: freq=0xFFFFFFF0, rate=0x20, len=2 → 0xFFFFFFF0, then 0x00000010.
4. Backpressure:
   - With the active segment running and the slot full, cfg_ready=0.
   - A held cfg_valid is accepted in the clk after a load empties the slot.
   - Required: no descriptor is lost or duplicated.
5. abort during 2nd sample of len=10 with a pending descriptor.
   - Required: nco_dv=0 from the next clk; busy=0; cfg_ready=1; nco_freq holds.
   - Required: later sample_en produces no output.
6. Unbounded and reset cases:
   - len=0 with rate=1: freq increments indefinitely. A queued descriptor takes over on the next sample_en with its start freq.
   - reset pulled low asynchronously mid-run: outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/doppler_ramp_ctrl.sv
// Doppler ramp sequencer: plays linear frequency segments into the NCO one
// sample per sample_en, with a one-deep pending slot for gapless chaining.
module doppler_ramp_ctrl #(
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned RATE_W = 24,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [FREQ_W-1:0] cfg_freq,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              abort,
  input  logic              sample_en,
  output logic              nco_dv,
  output logic [FREQ_W-1:0] nco_freq,
  output logic              busy,
  output logic              seg_done,
  output logic              underrun
);

  localparam int unsigned CNTX_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [FREQ_W-1:0]   acc, acc_nxt;
  logic [CNTX_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]    len, len_nxt;
  logic [RATE_W-1:0]   rate, rate_nxt;
  logic                pend_full, pend_full_nxt;
  logic [FREQ_W-1:0]   pend_freq, pend_freq_nxt;
  logic [RATE_W-1:0]   pend_rate, pend_rate_nxt;
  logic [CNT_W-1:0]    pend_len, pend_len_nxt;
  logic                nco_dv_nxt;
  logic [FREQ_W-1:0]   nco_freq_nxt;
  logic                busy_nxt;
  logic                seg_done_nxt;
  logic                underrun_nxt;

  logic                cfg_fire;
  logic                cnt_done;
  logic [CNTX_W-1:0]   cnt_inc;
  logic                do_load;
  logic                do_emit;
  logic                do_hold;

  assign cfg_ready = !pend_full;
  assign cfg_fire  = cfg_valid && !pend_full && !abort;
  assign cnt_inc   = cnt + CNTX_W'(1);
  // Bounded segment whose final sample has already gone out
  assign cnt_done  = (len != '0) && (cnt >= {1'b0, len});

  // Next-state and datapath decisions
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    len_nxt       = len;
    rate_nxt      = rate;
    pend_full_nxt = pend_full;
    pend_freq_nxt = pend_freq;
    pend_rate_nxt = pend_rate;
    pend_len_nxt  = pend_len;
    nco_dv_nxt    = 1'b0;
    nco_freq_nxt  = nco_freq;
    seg_done_nxt  = 1'b0;
    underrun_nxt  = 1'b0;
    do_load       = 1'b0;
    do_emit       = 1'b0;
    do_hold       = 1'b0;

    if (cfg_fire) begin
      pend_full_nxt = 1'b1;
      pend_freq_nxt = cfg_freq;
      pend_rate_nxt = cfg_rate;
      pend_len_nxt  = cfg_len;
    end

    case (state)
      ST_IDLE: begin
        if (sample_en && pend_full) do_load = 1'b1;
      end
      ST_RUN: begin
        if (sample_en) begin
          if (len == '0) begin
            if (pend_full) do_load = 1'b1;
            else           do_emit = 1'b1;
          end else if (cnt_done) begin
            if (pend_full) do_load = 1'b1;
            else           do_hold = 1'b1;
          end else begin
            do_emit = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (sample_en) begin
          if (pend_full) do_load = 1'b1;
          else           do_hold = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (do_load) begin
      nco_dv_nxt    = 1'b1;
      nco_freq_nxt  = pend_freq;
      acc_nxt       = pend_freq + FREQ_W'($signed(pend_rate));
      cnt_nxt       = CNTX_W'(1);
      len_nxt       = pend_len;
      rate_nxt      = pend_rate;
      pend_full_nxt = 1'b0;
      state_nxt     = ST_RUN;
      // Slot was just consumed, so a one-sample segment always underruns
      if (pend_len == CNT_W'(1)) begin
        seg_done_nxt = 1'b1;
        underrun_nxt = 1'b1;
        state_nxt    = ST_HOLD;
      end
    end

    if (do_emit) begin
      nco_dv_nxt   = 1'b1;
      nco_freq_nxt = acc;
      acc_nxt      = acc + FREQ_W'($signed(rate));
      cnt_nxt      = cnt_inc;
      if ((len != '0) && (cnt_inc == {1'b0, len})) begin
        seg_done_nxt = 1'b1;
        if (!pend_full) begin
          underrun_nxt = 1'b1;
          state_nxt    = ST_HOLD;
        end
      end
    end

    if (do_hold) begin
      nco_dv_nxt = 1'b1;
      state_nxt  = ST_HOLD;
    end

    if (abort) begin
      state_nxt     = ST_IDLE;
      acc_nxt       = acc;
      cnt_nxt       = cnt;
      len_nxt       = len;
      rate_nxt      = rate;
      pend_full_nxt = 1'b0;
      pend_freq_nxt = pend_freq;
      pend_rate_nxt = pend_rate;
      pend_len_nxt  = pend_len;
      nco_dv_nxt    = 1'b0;
      nco_freq_nxt  = nco_freq;
      seg_done_nxt  = 1'b0;
      underrun_nxt  = 1'b0;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      rate      <= '0;
      pend_full <= 1'b0;
      pend_freq <= '0;
      pend_rate <= '0;
      pend_len  <= '0;
      nco_dv    <= 1'b0;
      nco_freq  <= '0;
      busy      <= 1'b0;
      seg_done  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      len       <= len_nxt;
      rate      <= rate_nxt;
      pend_full <= pend_full_nxt;
      pend_freq <= pend_freq_nxt;
      pend_rate <= pend_rate_nxt;
      pend_len  <= pend_len_nxt;
      nco_dv    <= nco_dv_nxt;
      nco_freq  <= nco_freq_nxt;
      busy      <= busy_nxt;
      seg_done  <= seg_done_nxt;
      underrun  <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_doppler_ramp_ctrl.sv
// Scoreboard bench for doppler_ramp_ctrl: expected NCO samples are queued as
// sample strobes are driven and compared when nco_dv fires.
module tb_doppler_ramp_ctrl;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_freq;
  logic [23:0] cfg_rate;
  logic [19:0] cfg_len;
  logic        abort;
  logic        sample_en;
  logic        nco_dv;
  logic [31:0] nco_freq;
  logic        busy;
  logic        seg_done;
  logic        underrun;

  typedef struct packed {
    logic [31:0] f;
    logic        sd;
    logic        ur;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  doppler_ramp_ctrl #(.FREQ_W(32), .RATE_W(24), .CNT_W(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_freq  (cfg_freq),
    .cfg_rate  (cfg_rate),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .sample_en (sample_en),
    .nco_dv    (nco_dv),
    .nco_freq  (nco_freq),
    .busy      (busy),
    .seg_done  (seg_done),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with optional sample strobe; drains the scoreboard on nco_dv
  task automatic cyc(input logic se);
    exp_t e;
    logic want_dv;
    want_dv   = se && (exp_q.size() > 0);
    sample_en = se;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    checks++;
    if (nco_dv !== want_dv) begin
      failures++;
      $display("FAIL nco_dv t=%0t: got %b want %b", $time, nco_dv, want_dv);
    end
    if (want_dv) begin
      e = exp_q.pop_front();
      checks++;
      if (nco_freq !== e.f || seg_done !== e.sd || underrun !== e.ur) begin
        failures++;
        $display("FAIL sample t=%0t: got freq=%h sd=%b ur=%b want freq=%h sd=%b ur=%b",
                 $time, nco_freq, seg_done, underrun, e.f, e.sd, e.ur);
      end
    end else begin
      checks++;
      if (seg_done !== 1'b0 || underrun !== 1'b0) begin
        failures++;
        $display("FAIL stray_pulse t=%0t: got sd=%b ur=%b want 0 0", $time, seg_done, underrun);
      end
    end
  endtask

  task automatic set_cfg(input logic [31:0] f, input logic [23:0] r, input logic [19:0] l);
    cfg_freq  = f;
    cfg_rate  = r;
    cfg_len   = l;
    cfg_valid = 1'b1;
  endtask

  task automatic push(input logic [31:0] f, input logic sd, input logic ur);
    exp_t e;
    e.f  = f;
    e.sd = sd;
    e.ur = ur;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] f, input logic [23:0] r, input logic [19:0] l);
    set_cfg(f, r, l);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: got %b want 1", cfg_ready);
    end
    cyc(1'b0);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    checks++;
    if (nco_dv !== 1'b0 || nco_freq !== 32'h0 || busy !== 1'b0 ||
        seg_done !== 1'b0 || underrun !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got dv=%b f=%h busy=%b sd=%b ur=%b rdy=%b want 0 0 0 0 0 1",
               nco_dv, nco_freq, busy, seg_done, underrun, cfg_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b1);
  endtask

  task automatic test_single;
    send(32'h01234567, 24'h0, 20'd4);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_pending: got busy=%b rdy=%b want 0 0", busy, cfg_ready);
    end
    for (int i = 0; i < 4; i++) begin
      push(32'h01234567, i == 3, i == 3);
      cyc(1'b1);
      cyc(1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      push(32'h01234567, 1'b0, 1'b0);
      cyc(1'b1);
      cyc(1'b0);
    end
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_state: got busy=%b rdy=%b want 1 1", busy, cfg_ready);
    end
  endtask

  task automatic test_back_to_back;
    send(32'h100, 24'h10, 20'd3);
    push(32'h100, 1'b0, 1'b0);
    cyc(1'b1);
    send(32'h02468ACE, 24'hFFFFFF, 20'd2);
    for (int i = 1; i < 3; i++) begin
      push(32'h100 + 32'(i) * 32'h10, i == 2, 1'b0);
      cyc(1'b1);
      cyc(1'b0);
    end
    push(32'h02468ACE, 1'b0, 1'b0);
    cyc(1'b1);
    cyc(1'b0);
    push(32'h02468ACD, 1'b1, 1'b1);
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic test_wrap;
    send(32'hFFFFFFF0, 24'h20, 20'd2);
    push(32'hFFFFFFF0, 1'b0, 1'b0);
    cyc(1'b1);
    push(32'h00000010, 1'b1, 1'b1);
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic test_backpressure;
    send(32'h1000, 24'h1, 20'd3);
    set_cfg(32'h2000, 24'h2, 20'd2);
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got rdy=%b want 0", cfg_ready);
    end
    push(32'h1000, 1'b0, 1'b0);
    cyc(1'b1);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_freed: got rdy=%b want 1", cfg_ready);
    end
    cyc(1'b0);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_taken: got rdy=%b want 0", cfg_ready);
    end
    push(32'h1001, 1'b0, 1'b0);
    cyc(1'b1);
    push(32'h1002, 1'b1, 1'b0);
    cyc(1'b1);
    push(32'h2000, 1'b0, 1'b0);
    cyc(1'b1);
    push(32'h2002, 1'b1, 1'b1);
    cyc(1'b1);
    push(32'h2002, 1'b0, 1'b0);
    cyc(1'b1);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drained: got rdy=%b want 1", cfg_ready);
    end
  endtask

  task automatic test_abort;
    send(32'h5000, 24'h3, 20'd10);
    push(32'h5000, 1'b0, 1'b0);
    cyc(1'b1);
    send(32'h6000, 24'h0, 20'd5);
    push(32'h5003, 1'b0, 1'b0);
    cyc(1'b1);
    abort = 1'b1;
    cyc(1'b0);
    abort = 1'b0;
    checks++;
    if (nco_dv !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || nco_freq !== 32'h5003) begin
      failures++;
      $display("FAIL abort_state: got dv=%b busy=%b rdy=%b f=%h want 0 0 1 00005003",
               nco_dv, busy, cfg_ready, nco_freq);
    end
    cyc(1'b1);
    cyc(1'b0);
    abort = 1'b1;
    set_cfg(32'h7000, 24'h0, 20'd1);
    cyc(1'b0);
    abort     = 1'b0;
    cfg_valid = 1'b0;
    cyc(1'b1);
    checks++;
    if (nco_freq !== 32'h5003 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_discard: got f=%h busy=%b rdy=%b want 00005003 0 1",
               nco_freq, busy, cfg_ready);
    end
  endtask

  task automatic test_unbounded;
    send(32'h10, 24'h1, 20'd0);
    for (int i = 0; i < 4; i++) begin
      push(32'h10 + 32'(i), 1'b0, 1'b0);
      cyc(1'b1);
      cyc(1'b0);
    end
    send(32'hABC0, 24'h0, 20'd1);
    push(32'hABC0, 1'b1, 1'b1);
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic test_async_reset;
    send(32'h20, 24'h1, 20'd0);
    push(32'h20, 1'b0, 1'b0);
    cyc(1'b1);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (nco_dv !== 1'b0 || nco_freq !== 32'h0 || busy !== 1'b0 ||
        seg_done !== 1'b0 || underrun !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got dv=%b f=%h busy=%b sd=%b ur=%b rdy=%b want 0 0 0 0 0 1",
               nco_dv, nco_freq, busy, seg_done, underrun, cfg_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_rate  = '0;
    cfg_len   = '0;
    abort     = 1'b0;
    sample_en = 1'b0;

    test_reset;
    test_single;
    test_back_to_back;
    test_wrap;
    test_backpressure;
    test_abort;
    test_unbounded;
    test_async_reset;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
